mw_add_seq: RTL
===============

MW_ADD_SEQ -- requirements
Module: mw_add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of 16-bit slices per operand (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-006 SHALL have ports in_a and in_b, inputs, WORDS*16 bits each: the operands.
REQ-007 SHALL have port in_cin, input, 1 bit: the carry-in for the least significant slice.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_sum, output, WORDS*16 bits: the result.
REQ-011 SHALL have ports out_cout (carry out of the MSB) and out_ovf (signed overflow), outputs, 1 bit each.
REQ-012 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-013 SHALL time-share a single 16-bit prefix-adder slice, processing one slice per cycle from LSB to MSB and chaining the carry through a carry register.
REQ-014 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, SHALL capture in_a, in_b and in_cin, set idx=0 and carry=in_cin, and go to RUN.
REQ-016 RUN: each cycle, out_sum[idx*16+:16] SHALL be assigned the slice sum and carry SHALL be assigned the slice carry-out; idx SHALL increment; after the slice idx==WORDS-1, the FSM SHALL go to DONE.
REQ-017 DONE: out_valid=1; out_sum, out_cout and out_ovf SHALL be held stable until out_ready=1; on the handshake, the FSM SHALL go to IDLE.
REQ-018 out_valid SHALL assert exactly WORDS clock edges after the acceptance edge.
REQ-019 in_ready SHALL be 0 in RUN and DONE; there SHALL be no overlap between operations; the fastest throughput is one operation per WORDS+2 cycles.
REQ-020 out_ovf SHALL equal the carry into the MSB XOR the carry out of the MSB of the final slice.
REQ-021 Operands SHALL be captured at acceptance, so input changes after acceptance SHALL NOT affect the result.
REQ-022 in_valid asserted while not in IDLE SHALL be ignored (no capture and no error).
REQ-023 The idx counter SHALL be ceil(log2(WORDS)) bits wide and SHALL NOT wrap past WORDS-1.

Reset
REQ-024 rst_n=0 SHALL immediately force: state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0, idx=0, carry=0.
REQ-025 An assertion of rst_n during RUN or DONE SHALL abandon the operation with no partial result visible.

Configuration
REQ-026 Macro MW_ADD_SUB_EN: when defined, input port in_sub (1 bit) SHALL exist, and when in_sub=1 at acceptance, the block SHALL store ~in_b, force the initial carry to 1 (ignoring in_cin) and produce a-b.
REQ-027 When MW_ADD_SUB_EN is undefined, the in_sub port and the inversion logic SHALL be absent and the block SHALL only add.

Structure
REQ-028 A shared package mw_add_pkg SHALL hold the SLICE_W=16 constant and the FSM state enum (IDLE, RUN, DONE).
REQ-029 The block SHALL contain exactly one sub-module instance: brentkung (16-bit slice adder), fed by slice idx of the captured operands and by the carry register.

Verification
REQ-030 WORDS=4, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> out_sum=0, out_cout=1, out_ovf=0, with out_valid exactly 4 edges after acceptance.
REQ-031 a=0, b=0, cin=1 -> out_sum=1, out_cout=0; a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> out_sum=0x8000_0000_0000_0000, out_ovf=1.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; a concurrent in_valid SHALL be accepted only after the result handshake.
REQ-033 Assert rst_n=0 at the second RUN cycle -> out_valid=0 and in_ready=1 immediately; a following a=3, b=4 operation -> out_sum=7.
REQ-034 With MW_ADD_SUB_EN, a=5, b=7, in_sub=1 -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0; a=7, b=5 -> out_sum=2, out_cout=1.

Source files
------------

// File: rtl/mw_add_pkg.sv
// Shared constants and FSM encoding for the multi-word sequential adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mw_add_pkg;

    // Width of the time-shared adder slice.
    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mw_add_seq_brentkung.sv
// 16-bit Brent-Kung parallel-prefix adder slice with carry-in and carry-out.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports: a, b (slice operands), cin (slice carry-in), sum (slice sum), cout (slice carry-out).
module brentkung
    import mw_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    always_comb begin : prefix
        logic [SLICE_W-1:0] gg;
        logic [SLICE_W-1:0] pp;
        gg = a & b;
        pp = a ^ b;
        // Fold the carry-in into bit 0 so every group generate below already
        // includes it; gg[i] then becomes the carry into bit i+1.
        gg[0] = gg[0] | (pp[0] & cin);
        // Up-sweep: build group terms at positions 1,3,7,15.
        for (int d = 1; d < SLICE_W; d = d * 2) begin
            for (int i = 2 * d - 1; i < SLICE_W; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i - d]);
                pp[i] = pp[i] & pp[i - d];
            end
        end
        // Down-sweep: fill in the remaining prefix positions.
        for (int d = SLICE_W / 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < SLICE_W; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i - d]);
                pp[i] = pp[i] & pp[i - d];
            end
        end
        sum  = (a ^ b) ^ {gg[SLICE_W-2:0], cin};
        cout = gg[SLICE_W-1];
    end

endmodule

// File: rtl/mw_add_seq.sv
// Multi-word adder reusing one 16-bit slice adder, LSB slice first, carry chained in a register.
// Latency: out_valid rises WORDS edges after the accepting edge; one op per WORDS+2 cycles at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready with in_a, in_b, in_cin
// (plus in_sub when MW_ADD_SUB_EN is defined: subtract a-b); out_valid/out_ready with
// out_sum, out_cout, out_ovf (signed overflow); busy (high outside IDLE).
// Optional feature macro: MW_ADD_SUB_EN.
module mw_add_seq
    import mw_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORDS*SLICE_W-1:0] in_a,
    input  logic [WORDS*SLICE_W-1:0] in_b,
    input  logic                     in_cin,
`ifdef MW_ADD_SUB_EN
    input  logic                     in_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*SLICE_W-1:0] out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic                     busy
);

    localparam int W     = WORDS * SLICE_W;
    localparam int IDX_W = $clog2(WORDS);

    state_t             state_q;
    state_t             state_d;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               accept;
    logic               step;
    logic               last;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               msb_cin;

    assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];
    assign last    = (idx_q == IDX_W'(WORDS - 1));
    // Carry into the top bit recovered from the sum: s = a ^ b ^ c.
    assign msb_cin = slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_sum[SLICE_W-1];

    brentkung u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (accept) begin
            a_q   <= in_a;
            idx_q <= '0;
`ifdef MW_ADD_SUB_EN
            // a - b computed as a + ~b + 1.
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub | in_cin;
`else
            b_q     <= in_b;
            carry_q <= in_cin;
`endif
        end else if (step) begin
            out_sum[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
            carry_q <= slice_cout;
            if (last) begin
                out_cout <= slice_cout;
                out_ovf  <= msb_cin ^ slice_cout;
            end else begin
                // idx parks at WORDS-1 rather than wrapping.
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule
